// File: rtl/reg_file_mp_scoreboard.sv
// Multi-port ARM register file (3 read, 2 write) with a per-register busy scoreboard for RAW/WAW detection.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module reg_file_mp_scoreboard #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int RESET_MODE = 1,
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr0_en,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [WORD_WIDTH-1:0] wr0_data,
  input  logic                  wr1_en,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [WORD_WIDTH-1:0] wr1_data,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  input  logic [ADDR_WIDTH-1:0] rd2_addr,
  output logic [WORD_WIDTH-1:0] rd0_data,
  output logic [WORD_WIDTH-1:0] rd1_data,
  output logic [WORD_WIDTH-1:0] rd2_data,
  output logic [2:0]            rd_busy,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  output logic                  issue_waw,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic [WORD_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr [3];
  logic [WORD_WIDTH-1:0] rd_data [3];

  function automatic logic [WORD_WIDTH-1:0] reset_value(input int idx);
    if (RESET_MODE == 1) return WORD_WIDTH'(idx);
    return '0;
  endfunction

  // Port 1 is written last so it wins a same-address dual write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= reset_value(i);
    end else begin
      if (wr0_en) regs[wr0_addr] <= wr0_data;
      if (wr1_en) regs[wr1_addr] <= wr1_data;
    end
  end

  assign issue_waw = issue_en & busy_q[issue_dest];

  // A refused (WAW) issue leaves its bit alone; an accepted issue beats a same-cycle clear.
  always_comb begin
    busy_nxt = busy_q;
    if (wr0_en) busy_nxt[wr0_addr] = 1'b0;
    if (wr1_en) busy_nxt[wr1_addr] = 1'b0;
    if (issue_en && !issue_waw) busy_nxt[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  assign busy_vec   = busy_q;
  assign rd_addr[0] = rd0_addr;
  assign rd_addr[1] = rd1_addr;
  assign rd_addr[2] = rd2_addr;

  for (genvar k = 0; k < 3; k++) begin : g_rd
    logic hit0;
    logic hit1;
`ifdef RF_BYPASS_EN
    assign hit0 = ~rst & wr0_en & (wr0_addr == rd_addr[k]);
    assign hit1 = ~rst & wr1_en & (wr1_addr == rd_addr[k]);
`else
    assign hit0 = 1'b0;
    assign hit1 = 1'b0;
`endif
    // A forwarded operand is already available, so it is not a RAW hazard.
    assign rd_data[k] = hit1 ? wr1_data : (hit0 ? wr0_data : regs[rd_addr[k]]);
    assign rd_busy[k] = busy_q[rd_addr[k]] & ~(hit0 | hit1);
  end

  assign rd0_data = rd_data[0];
  assign rd1_data = rd_data[1];
  assign rd2_data = rd_data[2];

endmodule

// File: tb/tb_reg_file_mp_scoreboard.sv
// Randomised self-checking bench for reg_file_mp_scoreboard against an array/bitmask reference model,
// with hand-computed directed checks for reset, dual write, scoreboard, WAW, forwarding and mid-run reset.
module tb_reg_file_mp_scoreboard;
  localparam int WW = 32;
  localparam int AW = 4;
  localparam int NR = 16;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr0_en, wr1_en, issue_en;
  logic [AW-1:0] wr0_addr, wr1_addr, rd0_addr, rd1_addr, rd2_addr, issue_dest;
  logic [WW-1:0] wr0_data, wr1_data, rd0_data, rd1_data, rd2_data;
  logic [2:0]    rd_busy;
  logic          issue_waw;
  logic [NR-1:0] busy_vec;

  always #5 clk = ~clk;

  reg_file_mp_scoreboard #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .RESET_MODE(1)) dut (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data), .rd2_data(rd2_data),
    .rd_busy(rd_busy), .issue_en(issue_en), .issue_dest(issue_dest),
    .issue_waw(issue_waw), .busy_vec(busy_vec)
  );

  logic [WW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = WW'(i);
    m_busy = '0;
  endtask

  function automatic bit model_hit(input logic [AW-1:0] a);
    return BYP && !rst && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a));
  endfunction

  function automatic logic [WW-1:0] model_read(input logic [AW-1:0] a);
    if (BYP && !rst && wr1_en && wr1_addr == a) return wr1_data;
    if (BYP && !rst && wr0_en && wr0_addr == a) return wr0_data;
    return m_regs[a];
  endfunction

  task automatic compare_model();
    logic [2:0] exp_busy;
    exp_busy[0] = m_busy[rd0_addr] & ~model_hit(rd0_addr);
    exp_busy[1] = m_busy[rd1_addr] & ~model_hit(rd1_addr);
    exp_busy[2] = m_busy[rd2_addr] & ~model_hit(rd2_addr);
    chk("rd0_data", rd0_data, model_read(rd0_addr));
    chk("rd1_data", rd1_data, model_read(rd1_addr));
    chk("rd2_data", rd2_data, model_read(rd2_addr));
    chk("rd_busy", rd_busy, exp_busy);
    chk("issue_waw", issue_waw, issue_en & m_busy[issue_dest]);
    chk("busy_vec", busy_vec, m_busy);
  endtask

  // Applies the architectural effect of the edge just taken, using the inputs that were present at it.
  task automatic model_update();
    bit refused;
    if (rst) begin
      model_reset();
      return;
    end
    refused = issue_en && m_busy[issue_dest];
    if (wr0_en) begin m_regs[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
    if (wr1_en) begin m_regs[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
    if (issue_en && !refused) m_busy[issue_dest] = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic idle();
    wr0_en = 0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 0; wr1_addr = '0; wr1_data = '0;
    issue_en = 0; issue_dest = '0;
  endtask

  initial begin
    idle();
    rd0_addr = '0; rd1_addr = '0; rd2_addr = '0;
    m_busy = '0;

    // asynchronous reset asserted mid-cycle
    #7;
    rst = 1; rd0_addr = 3; rd1_addr = 7; rd2_addr = 15;
    #1;
    model_reset();
    chk("rst_rd0", rd0_data, 32'd3);
    chk("rst_rd1", rd1_data, 32'd7);
    chk("rst_rd2", rd2_data, 32'd15);
    chk("rst_busy", busy_vec, 16'h0000);
    cyc(); cyc();
    rst = 0;

    // dual write to different registers, then same-address dual write
    wr0_en = 1; wr0_addr = 2; wr0_data = 32'hAAAA_0000;
    wr1_en = 1; wr1_addr = 5; wr1_data = 32'h0000_5555;
    cyc(); idle();
    rd0_addr = 2; rd1_addr = 5; #1;
    chk("dual_r2", rd0_data, 32'hAAAA_0000);
    chk("dual_r5", rd1_data, 32'h0000_5555);
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'h1111_1111;
    wr1_en = 1; wr1_addr = 4; wr1_data = 32'h2222_2222;
    cyc(); idle();
    rd2_addr = 4; #1;
    chk("same_addr_r4", rd2_data, 32'h2222_2222);

    // scoreboard RAW flag until writeback
    issue_en = 1; issue_dest = 6;
    cyc(); idle();
    rd0_addr = 6; #1;
    chk("raw_busy0", rd_busy[0], 1'b1);
    chk("raw_vec", busy_vec, 16'h0040);
    cyc();
    wr0_en = 1; wr0_addr = 6; wr0_data = 32'h1234;
    cyc(); idle(); #1;
    chk("wb_busy_vec", busy_vec, 16'h0000);
    chk("wb_rd0", rd0_data, 32'h1234);

    // WAW refusal, then issue beating a same-cycle clear
    issue_en = 1; issue_dest = 8;
    cyc(); #1;
    chk("waw_flag", issue_waw, 1'b1);
    cyc(); idle(); #1;
    chk("waw_unchanged", busy_vec, 16'h0100);
    issue_en = 1; issue_dest = 9;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h99;
    cyc(); idle(); #1;
    chk("set_beats_clear", busy_vec, 16'h0300);

    // forwarding of an in-flight write to a busy register
    issue_en = 1; issue_dest = 1;
    cyc(); idle();
    wr0_en = 1; wr0_addr = 1; wr0_data = 32'hDEAD_BEEF; rd2_addr = 1; #1;
    chk("byp_rd2", rd2_data, BYP ? 32'hDEAD_BEEF : 32'd1);
    chk("byp_busy2", rd_busy[2], BYP ? 1'b0 : 1'b1);
    cyc(); idle();
    wr0_en = 1; wr0_addr = 8; wr1_en = 1; wr1_addr = 9;
    cyc(); idle();

    // reset in the middle of outstanding work with a write pending
    issue_en = 1; issue_dest = 6; cyc();
    issue_dest = 8; cyc(); idle(); #1;
    chk("pre_rst_busy", busy_vec, 16'h0140);
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF; rd0_addr = 0;
    #2 rst = 1; #1;
    model_reset();
    chk("midrst_busy", busy_vec, 16'h0000);
    chk("midrst_rd0", rd0_data, 32'd0);
    cyc(); #1;
    chk("midrst_wr_ignored", rd0_data, 32'd0);
    rst = 0; idle();

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      wr0_en = ($urandom_range(0, 2) == 0); wr0_addr = AW'($urandom); wr0_data = $urandom;
      wr1_en = ($urandom_range(0, 2) == 0); wr1_addr = AW'($urandom); wr1_data = $urandom;
      if ($urandom_range(0, 3) == 0) wr1_addr = wr0_addr;
      issue_en = ($urandom_range(0, 1) == 0); issue_dest = AW'($urandom);
      rd0_addr = AW'($urandom); rd1_addr = AW'($urandom); rd2_addr = AW'($urandom);
      if ($urandom_range(0, 3) == 0) rd1_addr = wr0_addr;
      if ($urandom_range(0, 3) == 0) rd2_addr = wr1_addr;
      if ($urandom_range(0, 79) == 0) begin
        rst = 1; #1; model_reset();
      end else begin
        rst = 0;
      end
      cyc();
    end
    rst = 0; idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
